// File: rtl/abc_stim_driver.sv
// rtl/abc_stim_driver.sv - exhaustive A/B/C stimulus sweep with per-pattern F capture
//
// Purpose:
//   On start, drives the eight A/B/C input combinations 000..111 to a piece of
//   logic under stimulus. Each pattern is held for HOLD_CYCLES cycles and then
//   the F response is sampled for one cycle. The sampled responses are stored
//   in resp and the number of F=1 responses in f_count. A one-cycle done pulse
//   marks the end of a sweep.
//
// Parameters:
//   HOLD_CYCLES  cycles each pattern is driven before F is sampled (1..15)
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   start        request one full 8-pattern sweep (accepted in IDLE only)
//   f_in         F response of the logic under stimulus
//   a_out        stimulus A (MSB of the pattern index)
//   b_out        stimulus B
//   c_out        stimulus C (LSB of the pattern index)
//   busy         high while a sweep is in progress
//   done         one-cycle pulse at the end of a sweep
//   resp[7:0]    resp[i] = F sampled for pattern i
//   f_count[3:0] number of patterns whose sampled F was 1
//
// Configuration:
//   ABC_DRV_LOOP_EN  when defined, start held high in DONE chains straight
//                    into the next sweep without passing through IDLE.

module abc_stim_driver #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       f_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] resp,
    output logic [3:0] f_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // The hold counter counts down to zero, so loading HOLD_CYCLES-1 gives
    // exactly HOLD_CYCLES cycles in DRIVE.
    localparam logic [3:0] HOLD_RELOAD = 4'(HOLD_CYCLES - 1);

    state_t     state;
    logic [2:0] idx;
    logic [3:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 3'd0;
            hold_cnt <= 4'd0;
            a_out    <= 1'b0;
            b_out    <= 1'b0;
            c_out    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            resp     <= 8'h00;
            f_count  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    {a_out, b_out, c_out} <= 3'b000;
                    if (start) begin
                        state    <= DRIVE;
                        idx      <= 3'd0;
                        hold_cnt <= HOLD_RELOAD;
                        busy     <= 1'b1;
                        resp     <= 8'h00;
                        f_count  <= 4'd0;
                    end
                end

                DRIVE: begin
                    if (hold_cnt == 4'd0) begin
                        state <= SAMPLE;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end

                SAMPLE: begin
                    resp[idx] <= f_in;
                    if (f_in) begin
                        f_count <= f_count + 4'd1;
                    end
                    if (idx == 3'd7) begin
                        // Last pattern: stimulus returns to zero together
                        // with the done pulse so DONE looks like IDLE.
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        {a_out, b_out, c_out} <= 3'b000;
                    end else begin
                        state    <= DRIVE;
                        idx      <= idx + 3'd1;
                        hold_cnt <= HOLD_RELOAD;
                        {a_out, b_out, c_out} <= idx + 3'd1;
                    end
                end

                DONE: begin
                    done <= 1'b0;
`ifdef ABC_DRV_LOOP_EN
                    if (start) begin
                        state    <= DRIVE;
                        idx      <= 3'd0;
                        hold_cnt <= HOLD_RELOAD;
                        busy     <= 1'b1;
                        resp     <= 8'h00;
                        f_count  <= 4'd0;
                        {a_out, b_out, c_out} <= 3'b000;
                    end else begin
                        state <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    {a_out, b_out, c_out} <= 3'b000;
                end
            endcase
        end
    end

endmodule
